// File: rtl/mdu_hilo_pkg.sv
// Shared encodings for the multiply/divide unit: md op codes, FSM states
// and the counter sizing helper used by mdu_hilo and the hazard unit.
package mdu_hilo_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  // Counter must hold the larger of the two latencies.
  function automatic int unsigned md_cnt_w(input int unsigned mult_cycles,
                                           input int unsigned div_cycles);
    int unsigned max_c;
    max_c = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    return int'($clog2(max_c)) + 1;
  endfunction

  // True for every op that touches the unit; the hazard unit stalls on these.
  function automatic logic md_is_md_class(input logic [OP_W-1:0] op);
    return op <= OP_W'(MD_MTLO);
  endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// E-stage request/response bundle between the pipeline and mdu_hilo.
interface mdu_hilo_if
  import mdu_hilo_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_hilo_arith.sv
// Combinational multiply/divide datapath: produces the {hi,lo} result for
// an md op plus a divide-by-zero flag.
module mdu_hilo_arith
  import mdu_hilo_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_c,
  output logic [WIDTH-1:0] lo_c,
  output logic             div0_c
);

  localparam int unsigned DW = 2 * WIDTH;

  logic [DW-1:0]    prod_s;
  logic [DW-1:0]    prod_u;
  logic             is_div;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] b_div;
  logic [WIDTH-1:0] uq;
  logic [WIDTH-1:0] ur;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  // Signed divide runs on magnitudes; the most negative dividend has a
  // magnitude of 2^(WIDTH-1), which makes the -MIN/-1 case fall out as MIN.
  always_comb begin
    prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    is_div = (op == OP_W'(MD_DIV)) || (op == OP_W'(MD_DIVU));
    div0_c = is_div && (b == '0);
    a_neg  = (op == OP_W'(MD_DIV)) && a[WIDTH-1];
    b_neg  = (op == OP_W'(MD_DIV)) && b[WIDTH-1];
    a_mag  = a_neg ? -a : a;
    b_mag  = b_neg ? -b : b;
    b_div  = (b_mag == '0) ? WIDTH'(1) : b_mag;
    uq     = a_mag / b_div;
    ur     = a_mag % b_div;
    quo    = (a_neg ^ b_neg) ? -uq : uq;
    rem    = a_neg ? -ur : ur;

    hi_c = '0;
    lo_c = '0;
    case (md_op_e'(op))
      MD_MULT:        {hi_c, lo_c} = prod_s;
      MD_MULTU:       {hi_c, lo_c} = prod_u;
      MD_DIV, MD_DIVU: begin
        hi_c = rem;
        lo_c = quo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed at issue and held until the latency counter expires.
module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  mdu_hilo_if.slave bus
);

  localparam int unsigned CNT_W = md_cnt_w(MULT_CYCLES, DIV_CYCLES);

  typedef struct packed {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
  } hilo_t;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  hilo_t            pend_q, pend_d;
  logic             pend_wr_q, pend_wr_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] arith_hi_c;
  logic [WIDTH-1:0] arith_lo_c;
  logic             arith_div0_c;
  md_op_e           op_e;

  assign op_e = md_op_e'(bus.op);

  mdu_hilo_arith #(
    .WIDTH (WIDTH)
  ) u_arith (
    .op     (bus.op),
    .a      (bus.a),
    .b      (bus.b),
    .hi_c   (arith_hi_c),
    .lo_c   (arith_lo_c),
    .div0_c (arith_div0_c)
  );

  // Next-state: requests are only honoured in IDLE; RUN just counts down.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (op_e)
            MD_MULT, MD_MULTU: begin
              pend_d    = '{hi: arith_hi_c, lo: arith_lo_c};
              pend_wr_d = 1'b1;
              cnt_d     = CNT_W'(MULT_CYCLES);
              state_d   = RUN;
            end
            MD_DIV, MD_DIVU: begin
              // A zero divisor still occupies the unit but leaves HI/LO alone.
              pend_d    = '{hi: arith_hi_c, lo: arith_lo_c};
              pend_wr_d = !arith_div0_c;
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = RUN;
            end
            MD_MTHI: hi_d = bus.a;
            MD_MTLO: lo_d = bus.a;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (pend_wr_q) begin
            hi_d = pend_q.hi;
            lo_d = pend_q.lo;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: two instances (5/10 and 1/32 cycle
// latencies) share one stimulus stream and are checked against a
// transaction-level arithmetic model.
module tb_mdu_hilo;

  localparam int unsigned W = 32;

  typedef struct {
    int          start_c;
    int          due;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    logic [31:0] hi;
    logic [31:0] lo;
  } md_exp_t;

  typedef struct {
    int          due;
    logic [31:0] hi;
    logic [31:0] lo;
  } mt_exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  int          cyc;
  int          checks;
  int          errors;
  logic [31:0] hi_w [2];
  logic [31:0] lo_w [2];
  logic        busy_w [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int g,
                                input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d: got %h expected %h", name, g, cyc, act, exp);
    end
  endfunction

  // Reference arithmetic straight from the instruction definitions.
  task automatic ref_md(input int o, input logic [31:0] x, input logic [31:0] y,
                        inout logic [31:0] h, inout logic [31:0] l);
    longint          p;
    longint unsigned pu;
    int              sx;
    int              sy;
    sx = x;
    sy = y;
    case (o)
      0: begin p = longint'(sx) * longint'(sy); h = p[63:32]; l = p[31:0]; end
      1: begin pu = {32'h0, x} * {32'h0, y}; h = pu[63:32]; l = pu[31:0]; end
      2: begin
        if (y != 0) begin
          if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            l = 32'h8000_0000;
            h = 32'h0;
          end else begin
            l = sx / sy;
            h = sx % sy;
          end
        end
      end
      3: begin
        if (y != 0) begin
          l = x / y;
          h = x % y;
        end
      end
      default: ;
    endcase
  endtask

  for (genvar G = 0; G < 2; G++) begin : g_dut
    localparam int MC = (G == 0) ? 5 : 1;
    localparam int DC = (G == 0) ? 10 : 32;

    mdu_hilo_if #(.WIDTH(W)) bus ();
    assign bus.start = start;
    assign bus.op    = op;
    assign bus.a     = a;
    assign bus.b     = b;
    assign hi_w[G]   = bus.hi;
    assign lo_w[G]   = bus.lo;
    assign busy_w[G] = bus.busy;

    mdu_hilo #(
      .WIDTH       (W),
      .MULT_CYCLES (MC),
      .DIV_CYCLES  (DC)
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );

    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          free_c;
    md_exp_t     md_q [$];
    mt_exp_t     mt_q [$];

    // Model: accepts a request only once the previous op has retired.
    initial begin
      md_exp_t e;
      m_hi   = '0;
      m_lo   = '0;
      free_c = 0;
      forever begin
        @(posedge clk);
        if (!reset) begin
          md_q.delete();
          mt_q.delete();
          m_hi   = '0;
          m_lo   = '0;
          free_c = 0;
          mt_q.push_back('{due: cyc + 1, hi: 32'h0, lo: 32'h0});
        end else if (start && cyc >= free_c) begin
          if (op <= 3'd3) begin
            e.start_c = cyc + 1;
            e.due     = cyc + 1 + ((op <= 3'd1) ? MC : DC);
            e.old_hi  = m_hi;
            e.old_lo  = m_lo;
            ref_md(int'(op), a, b, m_hi, m_lo);
            e.hi      = m_hi;
            e.lo      = m_lo;
            md_q.push_back(e);
            free_c    = e.due;
          end else if (op == 3'd4) begin
            m_hi = a;
            mt_q.push_back('{due: cyc + 1, hi: m_hi, lo: m_lo});
          end else if (op == 3'd5) begin
            m_lo = a;
            mt_q.push_back('{due: cyc + 1, hi: m_hi, lo: m_lo});
          end
        end
      end
    end

    // Monitor: pops an expected result on every done pulse.
    initial begin
      md_exp_t e;
      mt_exp_t m;
      logic    exp_busy;
      forever begin
        @(negedge clk);
        if (md_q.size() > 0 && cyc > md_q[0].due) begin
          checks++;
          errors++;
          $display("FAIL done_missing dut%0d cyc %0d: got none expected done at %0d",
                   G, cyc, md_q[0].due);
          void'(md_q.pop_front());
        end
        exp_busy = (md_q.size() > 0) && (cyc >= md_q[0].start_c) && (cyc < md_q[0].due);
        check("busy", G, 64'(bus.busy), 64'(exp_busy));
        if (exp_busy) begin
          check("hold_hi", G, 64'(bus.hi), 64'(md_q[0].old_hi));
          check("hold_lo", G, 64'(bus.lo), 64'(md_q[0].old_lo));
        end
        if (bus.done !== 1'b0) begin
          if (md_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done_spurious dut%0d cyc %0d: got done=%b expected 0", G, cyc, bus.done);
          end else begin
            e = md_q.pop_front();
            check("done_cyc", G, 64'(cyc), 64'(e.due));
            check("res_hi", G, 64'(bus.hi), 64'(e.hi));
            check("res_lo", G, 64'(bus.lo), 64'(e.lo));
          end
        end
        while (mt_q.size() > 0 && mt_q[0].due <= cyc) begin
          m = mt_q.pop_front();
          if (m.due == cyc) begin
            check("mt_hi", G, 64'(bus.hi), 64'(m.hi));
            check("mt_lo", G, 64'(bus.lo), 64'(m.lo));
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Operands are scrambled after the start cycle to prove single-cycle capture.
  task automatic issue(input int o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = 3'(o);
    a     = x;
    b     = y;
    tick(1);
    start = 1'b0;
    op    = 3'($urandom_range(0, 7));
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic spot(input string name, input logic [31:0] eh, input logic [31:0] el);
    check({name, "_hi"}, 0, 64'(hi_w[0]), 64'(eh));
    check({name, "_lo"}, 0, 64'(lo_w[0]), 64'(el));
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    start  = 1'b0;
    op     = 3'd7;
    a      = '0;
    b      = '0;
    tick(2);
    reset = 1'b1;
    spot("reset", 32'h0, 32'h0);
    check("reset_busy", 0, 64'(busy_w[0]), 64'h0);

    issue(0, 32'hFFFF_FFFE, 32'd3);
    tick(40);
    spot("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    issue(1, 32'hFFFF_FFFE, 32'd3);
    tick(40);
    spot("multu", 32'h0000_0002, 32'hFFFF_FFFA);
    issue(2, 32'hFFFF_FFF9, 32'd2);
    tick(40);
    spot("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(3, 32'd7, 32'd2);
    tick(40);
    spot("divu", 32'd1, 32'd3);
    issue(2, 32'h8000_0000, 32'hFFFF_FFFF);
    tick(40);
    spot("div_ovf", 32'h0, 32'h8000_0000);

    issue(4, 32'h11, 32'h0);
    issue(5, 32'h22, 32'h0);
    issue(2, 32'h1234, 32'h0);
    tick(40);
    spot("div0", 32'h11, 32'h22);

    issue(4, 32'hDEAD_BEEF, 32'h0);
    spot("mthi", 32'hDEAD_BEEF, 32'h22);
    check("mthi_busy", 0, 64'(busy_w[0]), 64'h0);
    issue(0, 32'd3, 32'd4);
    tick(1);
    issue(5, 32'd5, 32'h0);
    tick(40);
    spot("mtlo_ignored", 32'h0, 32'd12);

    issue(2, 32'd100, 32'd7);
    tick(2);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    spot("mid_reset", 32'h0, 32'h0);
    check("mid_reset_busy", 0, 64'(busy_w[0]), 64'h0);
    tick(40);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 60) == 0) begin
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
      end
      issue(int'($urandom_range(0, 7)), rand_opnd(), rand_opnd());
      tick(int'($urandom_range(0, 12)));
    end
    tick(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
